// File: rtl/axil_rr_arbiter.sv
// Shares one AXI-Lite slave between NUM_PORTS requesters. Write and read paths are
// arbitrated round-robin and independently, with one transaction in flight per direction.
module axil_rr_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             aclk,
    input  logic                             arst,

    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axil_awaddr,
    input  logic [NUM_PORTS*3-1:0]           s_axil_awprot,
    input  logic [NUM_PORTS-1:0]             s_axil_awvalid,
    output logic [NUM_PORTS-1:0]             s_axil_awready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0]  s_axil_wstrb,
    input  logic [NUM_PORTS-1:0]             s_axil_wvalid,
    output logic [NUM_PORTS-1:0]             s_axil_wready,
    output logic [1:0]                       s_axil_bresp,
    output logic [NUM_PORTS-1:0]             s_axil_bvalid,
    input  logic [NUM_PORTS-1:0]             s_axil_bready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axil_araddr,
    input  logic [NUM_PORTS*3-1:0]           s_axil_arprot,
    input  logic [NUM_PORTS-1:0]             s_axil_arvalid,
    output logic [NUM_PORTS-1:0]             s_axil_arready,
    output logic [DATA_WIDTH-1:0]            s_axil_rdata,
    output logic [1:0]                       s_axil_rresp,
    output logic [NUM_PORTS-1:0]             s_axil_rvalid,
    input  logic [NUM_PORTS-1:0]             s_axil_rready,

    output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
    output logic [2:0]                       m_axil_awprot,
    output logic                             m_axil_awvalid,
    input  logic                             m_axil_awready,
    output logic [DATA_WIDTH-1:0]            m_axil_wdata,
    output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
    output logic                             m_axil_wvalid,
    input  logic                             m_axil_wready,
    input  logic [1:0]                       m_axil_bresp,
    input  logic                             m_axil_bvalid,
    output logic                             m_axil_bready,
    output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
    output logic [2:0]                       m_axil_arprot,
    output logic                             m_axil_arvalid,
    input  logic                             m_axil_arready,
    input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
    input  logic [1:0]                       m_axil_rresp,
    input  logic                             m_axil_rvalid,
    output logic                             m_axil_rready,

    output logic [NUM_PORTS-1:0]             wr_grant,
    output logic [NUM_PORTS-1:0]             rd_grant
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0]     P_LAST = IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] P_ONE  = NUM_PORTS'(1);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    // Per-port views of the flattened slave buses.
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_awaddr, w_araddr;
    logic [NUM_PORTS-1:0][2:0]            w_awprot, w_arprot;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata;
    logic [NUM_PORTS-1:0][STRB_WIDTH-1:0] w_wstrb;

    assign w_awaddr = s_axil_awaddr;
    assign w_araddr = s_axil_araddr;
    assign w_awprot = s_axil_awprot;
    assign w_arprot = s_axil_arprot;
    assign w_wdata  = s_axil_wdata;
    assign w_wstrb  = s_axil_wstrb;

    // Returns {found, index}: first requester searching upward from last+1, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]     last);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_PORTS;
            if (req[cand]) res = {1'b1, cand[IDX_W-1:0]};
        end
        return res;
    endfunction

    // ---------------- write path ----------------
    wr_state_t              r_wr_state, w_wr_state_nxt;
    logic [IDX_W-1:0]       r_wr_idx, r_wr_last;
    logic [NUM_PORTS-1:0]   r_wr_grant;
    logic                   r_aw_done, r_w_done;
    logic                   r_m_awvalid;
    logic [ADDR_WIDTH-1:0]  r_m_awaddr;
    logic [2:0]             r_m_awprot;
    logic [IDX_W:0]         w_aw_pick;
    logic                   w_aw_found;
    logic [IDX_W-1:0]       w_aw_win;
    logic                   w_aw_hs, w_w_hs, w_b_hs;

    assign w_aw_pick  = rr_pick(s_axil_awvalid, r_wr_last);
    assign w_aw_found = w_aw_pick[IDX_W] & ~arst;
    assign w_aw_win   = w_aw_pick[IDX_W-1:0];

    assign w_aw_hs = r_m_awvalid & m_axil_awready;
    assign w_w_hs  = (r_wr_state == W_XFER) & ~r_w_done &
                     s_axil_wvalid[r_wr_idx] & m_axil_wready;
    assign w_b_hs  = (r_wr_state == W_RESP) & m_axil_bvalid & s_axil_bready[r_wr_idx];

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) r_wr_state <= W_IDLE;
        else      r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_found) begin
                    s_axil_awready = P_ONE << w_aw_win;
                    w_wr_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                if (!r_w_done) begin
                    m_axil_wvalid           = s_axil_wvalid[r_wr_idx];
                    s_axil_wready[r_wr_idx] = m_axil_wready;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axil_bvalid[r_wr_idx] = m_axil_bvalid;
                m_axil_bready           = s_axil_bready[r_wr_idx];
                if (w_b_hs) w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_wr_idx    <= '0;
            r_wr_last   <= P_LAST;
            r_wr_grant  <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_m_awvalid <= 1'b0;
            r_m_awaddr  <= '0;
            r_m_awprot  <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_found) begin
                        r_m_awaddr  <= w_awaddr[w_aw_win];
                        r_m_awprot  <= w_awprot[w_aw_win];
                        r_m_awvalid <= 1'b1;
                        r_wr_idx    <= w_aw_win;
                        r_wr_last   <= w_aw_win;
                        r_wr_grant  <= P_ONE << w_aw_win;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                    end
                end
                W_XFER: begin
                    if (w_aw_hs) begin
                        r_m_awvalid <= 1'b0;
                        r_aw_done   <= 1'b1;
                    end
                    if (w_w_hs) r_w_done <= 1'b1;
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_wr_grant <= '0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axil_awaddr  = r_m_awaddr;
    assign m_axil_awprot  = r_m_awprot;
    assign m_axil_awvalid = r_m_awvalid;
    assign m_axil_wdata   = w_wdata[r_wr_idx];
    assign m_axil_wstrb   = w_wstrb[r_wr_idx];
    assign s_axil_bresp   = m_axil_bresp;
    assign wr_grant       = r_wr_grant;

    // ---------------- read path ----------------
    rd_state_t              r_rd_state, w_rd_state_nxt;
    logic [IDX_W-1:0]       r_rd_idx, r_rd_last;
    logic [NUM_PORTS-1:0]   r_rd_grant;
    logic                   r_m_arvalid;
    logic [ADDR_WIDTH-1:0]  r_m_araddr;
    logic [2:0]             r_m_arprot;
    logic [IDX_W:0]         w_ar_pick;
    logic                   w_ar_found;
    logic [IDX_W-1:0]       w_ar_win;
    logic                   w_ar_hs, w_r_hs;

    assign w_ar_pick  = rr_pick(s_axil_arvalid, r_rd_last);
    assign w_ar_found = w_ar_pick[IDX_W] & ~arst;
    assign w_ar_win   = w_ar_pick[IDX_W-1:0];

    assign w_ar_hs = r_m_arvalid & m_axil_arready;
    assign w_r_hs  = (r_rd_state == R_DATA) & m_axil_rvalid & s_axil_rready[r_rd_idx];

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) r_rd_state <= R_IDLE;
        else      r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        m_axil_rready  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_found) begin
                    s_axil_arready = P_ONE << w_ar_win;
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (w_ar_hs) w_rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axil_rvalid[r_rd_idx] = m_axil_rvalid;
                m_axil_rready           = s_axil_rready[r_rd_idx];
                if (w_r_hs) w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_rd_idx    <= '0;
            r_rd_last   <= P_LAST;
            r_rd_grant  <= '0;
            r_m_arvalid <= 1'b0;
            r_m_araddr  <= '0;
            r_m_arprot  <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_found) begin
                        r_m_araddr  <= w_araddr[w_ar_win];
                        r_m_arprot  <= w_arprot[w_ar_win];
                        r_m_arvalid <= 1'b1;
                        r_rd_idx    <= w_ar_win;
                        r_rd_last   <= w_ar_win;
                        r_rd_grant  <= P_ONE << w_ar_win;
                    end
                end
                R_ADDR: begin
                    if (w_ar_hs) r_m_arvalid <= 1'b0;
                end
                R_DATA: begin
                    if (w_r_hs) r_rd_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign m_axil_araddr  = r_m_araddr;
    assign m_axil_arprot  = r_m_arprot;
    assign m_axil_arvalid = r_m_arvalid;
    assign s_axil_rdata   = m_axil_rdata;
    assign s_axil_rresp   = m_axil_rresp;
    assign rd_grant       = r_rd_grant;

endmodule
